// File: rtl/first_nios2_system_sysid_checker.sv
// Reads the two sysid words (ID, timestamp) after a start request and
// compares them against the values this image was built with.
module first_nios2_system_sysid_checker #(
   parameter logic [31:0] EXPECTED_ID        = 32'd1,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1688044928,
   parameter int unsigned READ_LATENCY       = 1
) (
   input  logic        clock,
   input  logic        reset_n,
   input  logic        start,
   output logic        sysid_address,
   output logic        sysid_read,
   input  logic [31:0] sysid_readdata,
   output logic        busy,
   output logic        done,
   output logic        pass,
   output logic        id_mismatch,
   output logic        ts_mismatch,
   output logic [31:0] id_value,
   output logic [31:0] ts_value
);

   localparam logic [3:0] CNT_RELOAD = 4'(READ_LATENCY - 1);

   typedef enum logic [1:0] {IDLE, RD_ID, RD_TS, DONE} state_t;

   state_t      state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        first_q, first_d;
   logic        done_q, done_d;
   logic        pass_q, pass_d;
   logic        id_mm_q, id_mm_d;
   logic        ts_mm_q, ts_mm_d;
   logic [31:0] id_value_q, id_value_d;
   logic [31:0] ts_value_q, ts_value_d;

   always_comb begin
      // NOTE: every target gets a default before the case, so no path can infer a latch.
      state_d    = state_q;
      cnt_d      = cnt_q;
      first_d    = first_q;
      done_d     = done_q;
      pass_d     = pass_q;
      id_mm_d    = id_mm_q;
      ts_mm_d    = ts_mm_q;
      id_value_d = id_value_q;
      ts_value_d = ts_value_q;

      unique case (state_q)
         IDLE, DONE: begin
            if (start) begin
               state_d = RD_ID;
               cnt_d   = CNT_RELOAD;
               first_d = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               id_mm_d = 1'b0;
               ts_mm_d = 1'b0;
            end
         end
         RD_ID: begin
            first_d = 1'b0;
            if (cnt_q == 4'd0) begin
               id_value_d = sysid_readdata;
               id_mm_d    = (sysid_readdata != EXPECTED_ID);
               cnt_d      = CNT_RELOAD;
               first_d    = 1'b1;
               state_d    = RD_TS;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         RD_TS: begin
            first_d = 1'b0;
            if (cnt_q == 4'd0) begin
               ts_value_d = sysid_readdata;
               ts_mm_d    = (sysid_readdata != EXPECTED_TIMESTAMP);
               done_d     = 1'b1;
               // Uses the flag values landing on this same edge, not the old ones.
               pass_d     = !(id_mm_d | ts_mm_d);
               state_d    = DONE;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         // NOTE: the captured words are plain registers, so they are reset like the rest.
         state_q    <= IDLE;
         cnt_q      <= 4'd0;
         first_q    <= 1'b0;
         done_q     <= 1'b0;
         pass_q     <= 1'b0;
         id_mm_q    <= 1'b0;
         ts_mm_q    <= 1'b0;
         id_value_q <= 32'd0;
         ts_value_q <= 32'd0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         first_q    <= first_d;
         done_q     <= done_d;
         pass_q     <= pass_d;
         id_mm_q    <= id_mm_d;
         ts_mm_q    <= ts_mm_d;
         id_value_q <= id_value_d;
         ts_value_q <= ts_value_d;
      end
   end

   // Strobe only on the first cycle of each read state; the slave is single-issue.
   assign busy          = (state_q == RD_ID) || (state_q == RD_TS);
   assign sysid_address = (state_q == RD_TS);
   assign sysid_read    = busy && first_q;
   assign done          = done_q;
   assign pass          = pass_q;
   assign id_mismatch   = id_mm_q;
   assign ts_mismatch   = ts_mm_q;
   assign id_value      = id_value_q;
   assign ts_value      = ts_value_q;

endmodule

// File: tb/tb_first_nios2_system_sysid_checker.sv
// Bench for the sysid checker: two instances (read latency 1 and 4) driven by a
// latency-accurate slave model, with random words checked against a reference model.
module tb_first_nios2_system_sysid_checker;

   localparam logic [31:0] EXP_ID = 32'd1;
   localparam logic [31:0] EXP_TS = 32'd1688044928;

   logic clock = 1'b0;
   always #5 clock = ~clock;

   logic [1:0]        rst_v   = 2'b00;
   logic [1:0]        start_v = 2'b00;
   logic [1:0]        addr_v, read_v, busy_v, done_v, pass_v, idmm_v, tsmm_v;
   logic [1:0][31:0]  rdata_v, idval_v, tsval_v;
   logic [1:0][31:0]  w0_v = '0, w1_v = '0;
   logic [1:0][31:0]  garbage = '0;
   logic [1:0][31:0]  exp_id_v = '0, exp_ts_v = '0;

   int          cyc = 0;
   int          issue_c [2] = '{-100, -100};
   logic [1:0]  issue_a = 2'b00;
   logic [1:0]  prev_read = 2'b00, prev_addr = 2'b00;
   int          rd_cnt [2] = '{0, 0};
   int          viol [2] = '{0, 0};
   logic [7:0]  addr_log [2] = '{8'd0, 8'd0};

   int n_tests = 0;
   int n_fail  = 0;

   first_nios2_system_sysid_checker dut0 (
      .clock(clock), .reset_n(rst_v[0]), .start(start_v[0]),
      .sysid_address(addr_v[0]), .sysid_read(read_v[0]), .sysid_readdata(rdata_v[0]),
      .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
      .id_mismatch(idmm_v[0]), .ts_mismatch(tsmm_v[0]),
      .id_value(idval_v[0]), .ts_value(tsval_v[0])
   );

   first_nios2_system_sysid_checker #(.READ_LATENCY(4)) dut1 (
      .clock(clock), .reset_n(rst_v[1]), .start(start_v[1]),
      .sysid_address(addr_v[1]), .sysid_read(read_v[1]), .sysid_readdata(rdata_v[1]),
      .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
      .id_mismatch(idmm_v[1]), .ts_mismatch(tsmm_v[1]),
      .id_value(idval_v[1]), .ts_value(tsval_v[1])
   );

   function automatic int lat_of(input int k);
      return (k == 0) ? 1 : 4;
   endfunction

   // Slave: data is valid only in the cycle lat-1 after the read cycle, random otherwise.
   always_comb begin
      for (int i = 0; i < 2; i++) begin
         int   ic;
         logic ia;
         ic = read_v[i] ? cyc : issue_c[i];
         ia = read_v[i] ? addr_v[i] : issue_a[i];
         rdata_v[i] = (cyc == ic + lat_of(i) - 1) ? (ia ? w1_v[i] : w0_v[i]) : garbage[i];
      end
   end

   // Bus monitor: counts read pulses, logs addresses, flags stretched or stray strobes.
   always @(posedge clock) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
         garbage[i] <= $urandom;
         if (read_v[i]) begin
            issue_c[i]  <= cyc;
            issue_a[i]  <= addr_v[i];
            rd_cnt[i]   <= rd_cnt[i] + 1;
            addr_log[i] <= {addr_log[i][6:0], addr_v[i]};
            if ((prev_read[i] && prev_addr[i] == addr_v[i]) || !busy_v[i])
               viol[i] <= viol[i] + 1;
         end
         prev_read[i] <= read_v[i];
         prev_addr[i] <= addr_v[i];
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] pick_word(input logic [31:0] good);
      case ($urandom_range(0, 2))
         0:       return good;
         1:       return good ^ (32'd1 << $urandom_range(0, 31));
         default: return $urandom;
      endcase
   endfunction

   // Called at a negedge: raises start now, holds it for `hold` edges, then checks the result.
   task automatic run_check(input int k, input logic [31:0] w0, input logic [31:0] w1,
                            input int hold);
      int lat, base, done_at, busy_n;
      lat     = lat_of(k);
      base    = rd_cnt[k];
      done_at = 0;
      busy_n  = 0;
      w0_v[k] = w0;
      w1_v[k] = w1;
      start_v[k] = 1'b1;
      for (int n = 1; n <= 2 * lat + 3 && done_at == 0; n++) begin
         @(posedge clock);
         @(negedge clock);
         if (n == hold) start_v[k] = 1'b0;
         if (n == 1) begin
            check("hold_id", idval_v[k], exp_id_v[k]);
            check("hold_ts", tsval_v[k], exp_ts_v[k]);
         end
         if (busy_v[k]) busy_n++;
         if (done_v[k]) done_at = n;
      end
      start_v[k] = 1'b0;
      check("latency", 32'(done_at - 1), 32'(2 * lat));
      check("busy_cycles", 32'(busy_n), 32'(2 * lat));
      exp_id_v[k] = w0;
      exp_ts_v[k] = w1;
      check("id_value", idval_v[k], w0);
      check("ts_value", tsval_v[k], w1);
      check("id_mismatch", 32'(idmm_v[k]), 32'(w0 != EXP_ID));
      check("ts_mismatch", 32'(tsmm_v[k]), 32'(w1 != EXP_TS));
      check("pass", 32'(pass_v[k]), 32'((w0 == EXP_ID) && (w1 == EXP_TS)));
      repeat (3) @(negedge clock);
      check("read_pulses", 32'(rd_cnt[k] - base), 32'd2);
      check("addr_order", 32'(addr_log[k][1:0]), 32'b01);
      check("done_sticky", 32'(done_v[k]), 32'd1);
   endtask

   initial begin
      #2;
      check("rst_outputs0", {addr_v[0], read_v[0], busy_v[0], done_v[0], pass_v[0],
                             idmm_v[0], tsmm_v[0], idval_v[0] | tsval_v[0]}, 32'd0);
      check("rst_outputs1", {addr_v[1], read_v[1], busy_v[1], done_v[1], pass_v[1],
                             idmm_v[1], tsmm_v[1], idval_v[1] | tsval_v[1]}, 32'd0);
      @(negedge clock);
      @(negedge clock);
      rst_v = 2'b11;
      // Start presented together with reset release must be taken on the very next edge.
      run_check(0, EXP_ID, EXP_TS, 1);
      run_check(0, EXP_ID, 32'd0, 1);
      run_check(0, EXP_ID ^ 32'h8000_0000, EXP_TS, 2);
      run_check(1, EXP_ID, EXP_TS, 1);
      run_check(1, 32'd0, EXP_TS ^ 32'h1, 5);
      run_check(0, EXP_ID, EXP_TS, 1);

      for (int it = 0; it < 8; it++) begin
         run_check(0, pick_word(EXP_ID), pick_word(EXP_TS), $urandom_range(1, 2));
         run_check(1, pick_word(EXP_ID), pick_word(EXP_TS), $urandom_range(1, 8));
      end

      // Abort in the middle of the timestamp read.
      w0_v[0] = EXP_ID;
      w1_v[0] = EXP_TS;
      start_v[0] = 1'b1;
      @(posedge clock);
      @(negedge clock);
      start_v[0] = 1'b0;
      @(posedge clock);
      @(negedge clock);
      check("pre_abort_ts_state", {30'd0, busy_v[0], addr_v[0]}, 32'd3);
      rst_v[0] = 1'b0;
      #1;
      check("abort_outputs", {addr_v[0], read_v[0], busy_v[0], done_v[0], pass_v[0],
                              idmm_v[0], tsmm_v[0], idval_v[0] | tsval_v[0]}, 32'd0);
      exp_id_v[0] = '0;
      exp_ts_v[0] = '0;
      repeat (2) begin
         @(negedge clock);
         check("abort_no_done", 32'(done_v[0]), 32'd0);
      end
      rst_v[0] = 1'b1;
      repeat (3) begin
         @(negedge clock);
         check("abort_waits", {30'd0, busy_v[0], done_v[0]}, 32'd0);
      end
      run_check(0, EXP_ID, EXP_TS, 1);

      check("strobe_rules0", 32'(viol[0]), 32'd0);
      check("strobe_rules1", 32'(viol[1]), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
